// File: rtl/huffman_encoding.sv
// Huffman encoder stage: buffers 4-bit symbols in a small FIFO and emits the
// matching 2-7 bit prefix code serially, MSB first, under CODING_RDY backpressure.
// Optional statistics counters (BIT_CNT, SYM_CNT) are built when HUFF_STATS_EN
// is defined.
module huffman_encoding #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  SYM_IN,
  input  logic        SYM_VALID,
  output logic        SYM_RDY,
  output logic        CODING_OUT,
  output logic        CODING_EN,
  input  logic        CODING_RDY,
  output logic        IDLE
`ifdef HUFF_STATS_EN
  ,
  output logic [31:0] BIT_CNT,
  output logic [15:0] SYM_CNT
`endif
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  // Symbol FIFO storage and bookkeeping
  logic [3:0]      fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;

  // Serialiser state
  state_e          state_q;
  logic [6:0]      shift_q;
  logic [2:0]      remain_q;
  logic            bit_fire;
  logic            last_bit;

  // Code ROM output for the symbol at the FIFO head
  logic [3:0]      head_sym;
  logic [6:0]      rom_code;
  logic [2:0]      rom_len;

  assign fifo_full  = (count_q == CntFull);
  assign fifo_empty = (count_q == '0);
  assign head_sym   = fifo_mem[rd_ptr_q];

  // No pass-through: a full FIFO refuses a push even when it pops this cycle
  assign SYM_RDY    = !fifo_full;
  assign push       = SYM_VALID && !fifo_full;

  assign bit_fire   = (state_q == StShift) && CODING_RDY;
  assign last_bit   = (remain_q == 3'd1);

  // Pop when the shifter is empty, or when its last bit leaves this cycle
  assign pop        = !fifo_empty &&
                      ((state_q == StIdle) || (bit_fire && last_bit));

  assign CODING_EN  = (state_q == StShift);
  assign CODING_OUT = shift_q[6];
  assign IDLE       = fifo_empty && (state_q == StIdle);

  // Code table: left-justified 7-bit code plus its length
  always_comb begin
    rom_code = 7'b0000000;
    rom_len  = 3'd7;
    unique case (head_sym)
      4'd0: begin rom_code = 7'b0000000; rom_len = 3'd2; end
      4'd1: begin rom_code = 7'b0100000; rom_len = 3'd2; end
      4'd2: begin rom_code = 7'b1000000; rom_len = 3'd3; end
      4'd3: begin rom_code = 7'b1010000; rom_len = 3'd3; end
      4'd4: begin rom_code = 7'b1100000; rom_len = 3'd4; end
      4'd5: begin rom_code = 7'b1101000; rom_len = 3'd4; end
      default: begin
        // 6..15 map to 111 followed by (sym-6) as four bits
        rom_code = {3'b111, head_sym - 4'd6};
        rom_len  = 3'd7;
      end
    endcase
  end

  // FIFO storage write; contents need no reset since count gates every read
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= SYM_IN;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntOne;
        2'b01:   count_q <= count_q - CntOne;
        default: count_q <= count_q;
      endcase
    end
  end

  // Serialiser FSM: loads a code from the FIFO head and shifts it out MSB first
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      remain_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            shift_q  <= rom_code;
            remain_q <= rom_len;
            state_q  <= StShift;
          end
        end
        StShift: begin
          if (bit_fire) begin
            if (!last_bit) begin
              shift_q  <= {shift_q[5:0], 1'b0};
              remain_q <= remain_q - 3'd1;
            end else if (pop) begin
              // Back-to-back codes: next code replaces the finished one, no bubble
              shift_q  <= rom_code;
              remain_q <= rom_len;
            end else begin
              shift_q  <= '0;
              remain_q <= '0;
              state_q  <= StIdle;
            end
          end
        end
        default: begin
          state_q  <= StIdle;
          shift_q  <= '0;
          remain_q <= '0;
        end
      endcase
    end
  end

`ifdef HUFF_STATS_EN
  // Free-running statistics: bits accepted downstream and symbols accepted
  always_ff @(posedge CLK) begin
    if (RST) begin
      BIT_CNT <= '0;
      SYM_CNT <= '0;
    end else begin
      if (bit_fire) begin
        BIT_CNT <= BIT_CNT + 32'd1;
      end
      if (push) begin
        SYM_CNT <= SYM_CNT + 16'd1;
      end
    end
  end
`endif

  // Occupancy never exceeds the FIFO depth
  assert property (@(posedge CLK) disable iff (RST) count_q <= CntFull);

  // A shifting code always has at least one bit left
  assert property (@(posedge CLK) disable iff (RST)
                   (state_q == StShift) |-> (remain_q != 3'd0));

endmodule

// File: tb/tb_huffman_encoding.sv
// Self-checking bench for huffman_encoding: a queue-based model of the symbol
// buffer and bit stream predicts every output each cycle, and a separate
// expected-stream queue checks each accepted bit against the code table.
module tb_huffman_encoding;

  localparam int unsigned Depth = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  SYM_IN;
  logic        SYM_VALID;
  logic        SYM_RDY;
  logic        CODING_OUT;
  logic        CODING_EN;
  logic        CODING_RDY;
  logic        IDLE;
`ifdef HUFF_STATS_EN
  logic [31:0] BIT_CNT;
  logic [15:0] SYM_CNT;
`endif

  always #5 CLK = ~CLK;

  huffman_encoding #(
    .FIFO_DEPTH(Depth)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .SYM_IN    (SYM_IN),
    .SYM_VALID (SYM_VALID),
    .SYM_RDY   (SYM_RDY),
    .CODING_OUT(CODING_OUT),
    .CODING_EN (CODING_EN),
    .CODING_RDY(CODING_RDY),
    .IDLE      (IDLE)
`ifdef HUFF_STATS_EN
    ,
    .BIT_CNT   (BIT_CNT),
    .SYM_CNT   (SYM_CNT)
`endif
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Model state: buffered symbols, bits of the code in flight, full expected stream
  int          fifo_q[$];
  bit          bits_q[$];
  bit          exp_stream[$];
  logic [31:0] m_bit_cnt = '0;
  logic [15:0] m_sym_cnt = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int code_len(input int s);
    if (s < 2) return 2;
    if (s < 4) return 3;
    if (s < 6) return 4;
    return 7;
  endfunction

  function automatic int code_val(input int s);
    if (s < 2) return s;
    if (s < 4) return 4 + (s - 2);
    if (s < 6) return 12 + (s - 4);
    return 112 + (s - 6);
  endfunction

  task automatic append_code(input int s, input bit to_stream);
    int len;
    int val;
    len = code_len(s);
    val = code_val(s);
    for (int i = len - 1; i >= 0; i--) begin
      if (to_stream) exp_stream.push_back(bit'((val >> i) & 1));
      else           bits_q.push_back(bit'((val >> i) & 1));
    end
  endtask

  // One clock cycle: drive, check outputs mid-cycle, advance model, cross the edge
  task automatic cyc(input bit rst, input bit vld, input logic [3:0] s, input bit rdy);
    bit e_rdy;
    bit e_en;
    bit e_out;
    bit e_idle;
    RST        = rst;
    SYM_VALID  = vld;
    SYM_IN     = s;
    CODING_RDY = rdy;
    #2;
    e_rdy  = (fifo_q.size() < Depth);
    e_en   = (bits_q.size() > 0);
    e_out  = e_en ? bits_q[0] : 1'b0;
    e_idle = (fifo_q.size() == 0) && !e_en;
    check_eq("sym_rdy", 32'(SYM_RDY), 32'(e_rdy));
    check_eq("coding_en", 32'(CODING_EN), 32'(e_en));
    check_eq("coding_out", 32'(CODING_OUT), 32'(e_out));
    check_eq("idle", 32'(IDLE), 32'(e_idle));
`ifdef HUFF_STATS_EN
    check_eq("bit_cnt", BIT_CNT, m_bit_cnt);
    check_eq("sym_cnt", 32'(SYM_CNT), 32'(m_sym_cnt));
`endif
    if (!rst && CODING_EN && rdy) begin
      if (exp_stream.size() > 0) check_eq("stream_bit", 32'(CODING_OUT), 32'(exp_stream.pop_front()));
      else                       check_eq("stream_extra", 32'(CODING_OUT), 32'd2);
    end
    if (rst) begin
      fifo_q.delete();
      bits_q.delete();
      exp_stream.delete();
      m_bit_cnt = '0;
      m_sym_cnt = '0;
    end else begin
      if (e_en && rdy) begin
        void'(bits_q.pop_front());
        m_bit_cnt = m_bit_cnt + 32'd1;
      end
      if (bits_q.size() == 0 && fifo_q.size() > 0) append_code(fifo_q.pop_front(), 1'b0);
      if (vld && e_rdy) begin
        fifo_q.push_back(int'(s));
        append_code(int'(s), 1'b1);
        m_sym_cnt = m_sym_cnt + 16'd1;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_cycles(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'd0, rdy);
  endtask

  initial begin
    logic [3:0] seq_a [3];
    seq_a[0] = 4'd0;
    seq_a[1] = 4'd1;
    seq_a[2] = 4'd15;

    // Initial reset without checks; model starts empty
    RST = 1'b1; SYM_VALID = 1'b0; SYM_IN = '0; CODING_RDY = 1'b0;
    @(posedge CLK);
    #1;
    cyc(1'b1, 1'b0, 4'd0, 1'b1);
    idle_cycles(2, 1'b1);

    // Single symbol 2, downstream always ready
    cyc(1'b0, 1'b1, 4'd2, 1'b1);
    idle_cycles(6, 1'b1);

    // Back-to-back 0,1,15 forming one contiguous stream
    cyc(1'b1, 1'b0, 4'd0, 1'b1);
    foreach (seq_a[i]) cyc(1'b0, 1'b1, seq_a[i], 1'b1);
    idle_cycles(14, 1'b1);
`ifdef HUFF_STATS_EN
    check_eq("bit_cnt_seq", BIT_CNT, 32'd11);
    check_eq("sym_cnt_seq", 32'(SYM_CNT), 32'd3);
`endif

    // Stall downstream while offering six symbols, then drain
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 4'($urandom_range(15)), 1'b0);
    idle_cycles(3, 1'b0);
    idle_cycles(40, 1'b1);

    // Symbol 5 under alternating ready
    cyc(1'b0, 1'b1, 4'd5, 1'b1);
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 4'd0, bit'(i % 2));
    idle_cycles(3, 1'b1);

    // Reset after three bits of symbol 9, then symbol 3 alone
    cyc(1'b0, 1'b1, 4'd9, 1'b1);
    idle_cycles(4, 1'b1);
    cyc(1'b1, 1'b0, 4'd0, 1'b1);
    cyc(1'b0, 1'b1, 4'd3, 1'b1);
    idle_cycles(6, 1'b1);

    // Full FIFO with offered symbols while pops occur
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 4'(i), 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 4'(6 + i % 10), 1'b1);
    idle_cycles(60, 1'b1);

    // Randomised traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      cyc(bit'($urandom_range(299) == 0), bit'($urandom_range(1)),
          4'($urandom_range(15)), bit'($urandom_range(3) != 0));
    end
    idle_cycles(80, 1'b1);
    check_eq("final_idle", 32'(IDLE), 32'd1);
    check_eq("stream_left", exp_stream.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
